pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//   Central stall sequencer for the 5-stage pipeline. Freezes or advances the
//   PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and runs the
//   multi-cycle iterative MUL/DIV unit in EX. It also inserts a load-use bubble.
//   It replaces the per-register local stall counters with one shared schedule.
// PARAMETERS
//   MUL_CYCLES  32  iteration cycles of the multiplier (BUSY length for MULT)
//   DIV_CYCLES  32  iteration cycles of the divider (BUSY length for DIV)
//   CNT_W        6  width of iteration counter; must hold max(MUL,DIV)_CYCLES-1
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   mul_req      in   1      instruction in EX (ID/EX output) is MULT/DIV
//   mul_op       in   2      01=MULT, 10=DIV; 00/11 treated as MULT
//   load_use     in   1      hazard unit: ID instr reads rt of load in EX
//   en_pc        out  1      PC write enable
//   en_if_id     out  1      IF/ID enable
//   en_id_ex     out  1      ID/EX enable
//   flush_id_ex  out  1      ID/EX loads a bubble (all-zero ctrl) this edge
//   en_ex_mem    out  1      EX/MEM enable
//   en_mem_wb    out  1      MEM/WB enable
//   mul_start    out  1      1-cycle pulse: MUL/DIV unit latches operands+op
//   mul_busy     out  1      state==BUSY
//   mul_done     out  1      state==DONE; EX result mux selects HI/LO result
//   iter_cnt     out  CNT_W  current iteration index (0 outside BUSY)
//   stall_count  out  16     perf counter of frozen/bubble cycles, saturating
// BEHAVIOUR
//   FSM states IDLE, BUSY, DONE; registered state, iter_cnt, op_q, stall_count.
//   Reset (rst=1 at edge): state<=IDLE, iter_cnt<=0, op_q<=MULT, stall_count<=0.
//   While rst=1, outputs are forced: all en_*=0, flush_id_ex=0, mul_start=0,
//     mul_busy=0, mul_done=0.
//   IDLE, mul_req=1: mul_start=1, all en_*=0, op_q<=mul_op, iter_cnt<=0,
//     go to BUSY. mul_req has priority over load_use.
//   IDLE, mul_req=0, load_use=1: en_pc=en_if_id=0; en_id_ex=en_ex_mem=
//     en_mem_wb=1; flush_id_ex=1; stay IDLE. This is one bubble per cycle
//     asserted.
//   IDLE, neither request: all en_*=1, flush_id_ex=0.
//   BUSY: all en_*=0. iter_cnt increments every cycle. When iter_cnt==N-1
//     (N=MUL_CYCLES if op_q!=DIV else DIV_CYCLES): iter_cnt<=0, go to DONE.
//   DONE (exactly 1 cycle): mul_done=1, all en_*=1, flush_id_ex=0. mul_req and
//     load_use are ignored. Always go to IDLE.
//   Total freeze per MULT = 1 (start) + N (BUSY) cycles; the result advances
//     on the DONE edge.
//   Back-to-back MUL: the next instr in ID/EX is sampled in IDLE after DONE, so
//     a new mul_start comes 1 cycle after DONE.
//   stall_count: +1 on every non-reset cycle where en_pc=0. It saturates at 0xFFFF
//     and does not wrap.
//   Reset mid-BUSY: the next cycle is IDLE with iter_cnt=0. No mul_done pulse; the
//     aborted op is discarded.
//   mul_req/mul_op changes during BUSY are ignored; op_q is fixed at start.
//   All outputs are combinational from state and inputs. No output depends on
//     iter_cnt except the BUSY->DONE transition.
// TESTING
//   Reset: rst=1 2 cycles -> all en_*=0, iter_cnt=0, stall_count=0; rst=0, no
//     req -> all en_*=1.
//   MULT at cycle t (mul_req=1, op=01) -> mul_start=1 only at t; en_*=0 for
//     t..t+32; mul_done=1 and en_*=1 at t+33; stall_count=33.
//   DIV with DIV_CYCLES=34 (op=10) -> mul_busy for 34 cycles; mul_done at t+35.
//   load_use=1 for 1 cycle in IDLE -> en_pc=en_if_id=0, flush_id_ex=1, other
//     en=1; stall_count +1.
//   mul_req held high through DONE -> second mul_start at DONE+1. Check
//     load_use=1 and mul_req=1 together -> mul wins, flush_id_ex=0.
//   rst at iter_cnt=10 in BUSY -> IDLE next cycle, iter_cnt=0, no mul_done;
//     stall_count forced to 0xFFFF via long stall stays 0xFFFF.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer: freezes/advances the pipeline registers, sequences the
// iterative MUL/DIV unit in EX and inserts load-use bubbles into ID/EX.
module pipe_stall_ctrl #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_req,
  input  logic [1:0]       mul_op,
  input  logic             load_use,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             flush_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             mul_start,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [CNT_W-1:0] iter_cnt,
  output logic [15:0]      stall_count
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [1:0]       OpMul   = 2'b01;
  localparam logic [1:0]       OpDiv   = 2'b10;
  localparam logic [CNT_W-1:0] MulLast = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [1:0]       op_q, op_d;
  logic [15:0]      stall_q, stall_d;
  logic [CNT_W-1:0] last_iter;

  // Encodings other than DIV run the multiplier schedule.
  assign last_iter = (op_q == OpDiv) ? DivLast : MulLast;

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    op_d        = op_q;
    en_pc       = 1'b0;
    en_if_id    = 1'b0;
    en_id_ex    = 1'b0;
    en_ex_mem   = 1'b0;
    en_mem_wb   = 1'b0;
    flush_id_ex = 1'b0;
    mul_start   = 1'b0;
    mul_busy    = 1'b0;
    mul_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mul_req) begin
          mul_start = 1'b1;
          op_d      = mul_op;
          iter_d    = '0;
          state_d   = StBusy;
        end else if (load_use) begin
          // Hold PC and IF/ID, drain the rest and bubble ID/EX.
          en_id_ex    = 1'b1;
          en_ex_mem   = 1'b1;
          en_mem_wb   = 1'b1;
          flush_id_ex = 1'b1;
        end else begin
          en_pc     = 1'b1;
          en_if_id  = 1'b1;
          en_id_ex  = 1'b1;
          en_ex_mem = 1'b1;
          en_mem_wb = 1'b1;
        end
      end
      StBusy: begin
        mul_busy = 1'b1;
        if (iter_q == last_iter) begin
          iter_d  = '0;
          state_d = StDone;
        end else begin
          iter_d = iter_q + CNT_W'(1);
        end
      end
      StDone: begin
        mul_done  = 1'b1;
        en_pc     = 1'b1;
        en_if_id  = 1'b1;
        en_id_ex  = 1'b1;
        en_ex_mem = 1'b1;
        en_mem_wb = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
        iter_d  = '0;
      end
    endcase

    // Counter holds at all-ones instead of wrapping.
    stall_d = stall_q;
    if (!en_pc && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (rst) begin
      en_pc       = 1'b0;
      en_if_id    = 1'b0;
      en_id_ex    = 1'b0;
      en_ex_mem   = 1'b0;
      en_mem_wb   = 1'b0;
      flush_id_ex = 1'b0;
      mul_start   = 1'b0;
      mul_busy    = 1'b0;
      mul_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      iter_q  <= '0;
      op_q    <= OpMul;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      op_q    <= op_d;
      stall_q <= stall_d;
    end
  end

  assign iter_cnt    = iter_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MUL_CYCLES=32 and DIV_CYCLES=34.
module tb_pipe_stall_ctrl;

  localparam int unsigned CntW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            mul_req;
  logic [1:0]      mul_op;
  logic            load_use;
  logic            en_pc, en_if_id, en_id_ex, flush_id_ex, en_ex_mem, en_mem_wb;
  logic            mul_start, mul_busy, mul_done;
  logic [CntW-1:0] iter_cnt;
  logic [15:0]     stall_count;
  logic [4:0]      ens;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stall_ctrl #(
    .MUL_CYCLES(32),
    .DIV_CYCLES(34),
    .CNT_W     (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_req    (mul_req),
    .mul_op     (mul_op),
    .load_use   (load_use),
    .en_pc      (en_pc),
    .en_if_id   (en_if_id),
    .en_id_ex   (en_id_ex),
    .flush_id_ex(flush_id_ex),
    .en_ex_mem  (en_ex_mem),
    .en_mem_wb  (en_mem_wb),
    .mul_start  (mul_start),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done),
    .iter_cnt   (iter_cnt),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign ens = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen_done;
    rst      = 1'b1;
    mul_req  = 1'b0;
    mul_op   = 2'b01;
    load_use = 1'b0;

    // Reset for two cycles; a request during reset must not start anything.
    cyc(); #1;
    chk("rst_ens", ens, 5'b00000);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_stall", stall_count, 0);
    cyc(); mul_req = 1'b1; load_use = 1'b1; #1;
    chk("rst_start", mul_start, 0);
    chk("rst_flush", flush_id_ex, 0);
    chk("rst_ens2", ens, 5'b00000);

    cyc(); rst = 1'b0; mul_req = 1'b0; load_use = 1'b0; #1;
    chk("idle_ens", ens, 5'b11111);
    chk("idle_busy", mul_busy, 0);
    chk("idle_done", mul_done, 0);

    // Single load-use bubble.
    cyc(); load_use = 1'b1; #1;
    chk("lu_ens", ens, 5'b00111);
    chk("lu_flush", flush_id_ex, 1);
    cyc(); load_use = 1'b0; #1;
    chk("lu_after_ens", ens, 5'b11111);
    chk("lu_stall", stall_count, 1);

    // MULT: start at t, BUSY t+1..t+32, DONE t+33.
    cyc(); mul_req = 1'b1; mul_op = 2'b01; #1;
    chk("mul_start", mul_start, 1);
    chk("mul_start_ens", ens, 5'b00000);
    chk("mul_start_flush", flush_id_ex, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc(); mul_req = 1'b0; #1;
      chk("mul_busy", mul_busy, 1);
      chk("mul_iter", iter_cnt, k - 1);
      chk("mul_busy_ens", ens, 5'b00000);
      chk("mul_busy_start", mul_start, 0);
    end
    cyc(); #1;
    chk("mul_done", mul_done, 1);
    chk("mul_done_busy", mul_busy, 0);
    chk("mul_done_ens", ens, 5'b11111);
    chk("mul_stall", stall_count, 34);
    cyc(); #1;
    chk("mul_post_done", mul_done, 0);
    chk("mul_post_ens", ens, 5'b11111);

    // DIV: 34 BUSY cycles; inputs wiggle during BUSY and must be ignored.
    cyc(); mul_req = 1'b1; mul_op = 2'b10; #1;
    chk("div_start", mul_start, 1);
    for (int k = 1; k <= 34; k++) begin
      cyc(); mul_req = k[0]; mul_op = 2'b01; #1;
      chk("div_busy", mul_busy, 1);
      chk("div_iter", iter_cnt, k - 1);
      chk("div_done_early", mul_done, 0);
    end
    cyc(); mul_req = 1'b0; #1;
    chk("div_done", mul_done, 1);
    chk("div_done_ens", ens, 5'b11111);
    chk("div_stall", stall_count, 69);

    // Back-to-back MULT with load_use also asserted: mul wins, no flush.
    cyc(); mul_req = 1'b1; mul_op = 2'b01; load_use = 1'b1; #1;
    chk("b2b_start1", mul_start, 1);
    chk("b2b_flush1", flush_id_ex, 0);
    chk("b2b_ens1", ens, 5'b00000);
    for (int k = 1; k <= 32; k++) begin
      cyc(); #1;
      chk("b2b_busy", mul_busy, 1);
    end
    cyc(); #1;
    chk("b2b_done", mul_done, 1);
    chk("b2b_done_start", mul_start, 0);
    chk("b2b_done_flush", flush_id_ex, 0);
    chk("b2b_done_ens", ens, 5'b11111);
    cyc(); #1;
    chk("b2b_start2", mul_start, 1);
    chk("b2b_flush2", flush_id_ex, 0);
    chk("b2b_ens2", ens, 5'b00000);

    // Reset while the second op is at iter_cnt == 10.
    cyc(); mul_req = 1'b0; load_use = 1'b0; #1;
    chk("abort_iter0", iter_cnt, 0);
    for (int k = 1; k <= 10; k++) cyc();
    #1;
    chk("abort_iter10", iter_cnt, 10);
    rst = 1'b1; #1;
    chk("abort_rst_busy", mul_busy, 0);
    chk("abort_rst_ens", ens, 5'b00000);
    cyc(); rst = 1'b0; #1;
    chk("abort_idle_busy", mul_busy, 0);
    chk("abort_idle_iter", iter_cnt, 0);
    chk("abort_idle_ens", ens, 5'b11111);
    chk("abort_idle_stall", stall_count, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(); #1;
      seen_done = seen_done | mul_done;
    end
    chk("abort_no_done", seen_done, 0);

    // Saturation of the stall counter through a long load-use stall.
    cyc(); load_use = 1'b1; #1;
    chk("sat_start", stall_count, 0);
    for (int k = 0; k < 65534; k++) cyc();
    #1;
    chk("sat_fffe", stall_count, 16'hFFFE);
    cyc(); #1;
    chk("sat_ffff", stall_count, 16'hFFFF);
    for (int k = 0; k < 20; k++) cyc();
    #1;
    chk("sat_hold", stall_count, 16'hFFFF);
    chk("sat_lu_flush", flush_id_ex, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
